// File: rtl/mines_game_ctrl.sv
// mines_game_ctrl: top-level sequencer for the 8x8 minesweeper game.
// Ports:
//   clk, rst (async, active-high)
//   start_game, btn_up/down/left/right, btn_reveal, btn_flag : single-cycle input pulses
//   gen_start (out pulse) / gen_done (in level)              : board generator handshake
//   cell_addr (out {row,col}) / cell_data (in, bit5=bomb, [3:0]=count) : board RAM read port
//   cursor_row, cursor_col, revealed, flagged, revealed_count, flags_left : game state
//   state (IDLE=0 GEN=1 PLAY=2 CHECK=3 FLOOD=4 WIN=5 LOSE=6), game_won, game_lost
// Optional: define REVEAL_BOMBS_ON_LOSE_EN to sweep the board on a loss and reveal every bomb.
module mines_game_ctrl #(
  parameter int N_BOMBS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_reveal,
  input  logic        btn_flag,
  output logic        gen_start,
  input  logic        gen_done,
  output logic [5:0]  cell_addr,
  input  logic [7:0]  cell_data,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic [63:0] revealed,
  output logic [63:0] flagged,
  output logic [6:0]  revealed_count,
  output logic [7:0]  flags_left,
  output logic [2:0]  state,
  output logic        game_won,
  output logic        game_lost
);
  localparam logic [2:0] S_IDLE = 3'd0, S_GEN = 3'd1, S_PLAY = 3'd2, S_CHECK = 3'd3,
                         S_FLOOD = 3'd4, S_WIN = 3'd5, S_LOSE = 3'd6;
  localparam logic [6:0] TARGET = 7'(64 - N_BOMBS);
  localparam logic [7:0] FLAGS0 = 8'(N_BOMBS);

  logic [2:0]  state_q, state_d;
  logic [2:0]  row_q, col_q;
  logic [63:0] revealed_q, flagged_q;
  logic [6:0]  count_q;
  logic [7:0]  flags_q;
  logic [5:0]  scan_q;
  logic        changed_q;
  logic        gen_start_q;
  logic [5:0]  cur;
  logic        restart;
  logic        can_reveal;
  logic        expand;
  logic [63:0] nb_mask;
  logic [63:0] new_bits;
  logic [3:0]  n_new;
  logic [6:0]  count_inc;
  logic        sweep_on;
  logic        unused_bits;
`ifdef REVEAL_BOMBS_ON_LOSE_EN
  logic [5:0]  sweep_q;
  logic        sweep_on_q;
  assign sweep_on = sweep_on_q;
`else
  assign sweep_on = 1'b0;
`endif

  function automatic logic [6:0] sat_add(input logic [6:0] a, input logic [3:0] b);
    logic [7:0] s;
    s = {1'b0, a} + {4'b0, b};
    return (s > 8'd64) ? 7'd64 : s[6:0];
  endfunction

  assign unused_bits = ^{cell_data[7:6], cell_data[4]};
  assign cur         = {row_q, col_q};
  assign restart     = start_game && (state_q == S_IDLE || state_q == S_PLAY ||
                                      state_q == S_WIN  || state_q == S_LOSE);
  assign can_reveal  = !revealed_q[cur] && !flagged_q[cur];
  assign count_inc   = sat_add(count_q, 4'd1);

  // In-bounds (non-wrapping) 8-neighbourhood of the cell being scanned.
  always_comb begin
    int r, c;
    r = 0;
    c = 0;
    nb_mask = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(scan_q[5:3]) + dr;
        c = int'(scan_q[2:0]) + dc;
        if ((dr != 0 || dc != 0) && r >= 0 && r < 8 && c >= 0 && c < 8)
          nb_mask[6'(r * 8 + c)] = 1'b1;
      end
  end

  assign expand   = (state_q == S_FLOOD) && revealed_q[scan_q] && !cell_data[5] && (cell_data[3:0] == 4'd0);
  assign new_bits = expand ? (nb_mask & ~revealed_q & ~flagged_q) : '0;
  assign n_new    = 4'($countones(new_bits));

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start_game ? S_GEN : S_IDLE;
      S_GEN:   state_d = gen_done ? S_PLAY : S_GEN;
      S_PLAY:  state_d = start_game ? S_GEN : (btn_reveal && can_reveal) ? S_CHECK : S_PLAY;
      S_CHECK: state_d = cell_data[5] ? S_LOSE : (count_inc >= TARGET) ? S_WIN :
                         (cell_data[3:0] == 4'd0) ? S_FLOOD : S_PLAY;
      // Another pass is needed whenever anything changed during this one, including its last cell.
      S_FLOOD: state_d = (scan_q != 6'd63 || changed_q || n_new != 4'd0) ? S_FLOOD :
                         (count_q >= TARGET) ? S_WIN : S_PLAY;
      S_WIN, S_LOSE: state_d = start_game ? S_GEN : state_q;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cell_addr = (state_q == S_PLAY || state_q == S_CHECK) ? cur :
                (state_q == S_FLOOD) ? scan_q :
`ifdef REVEAL_BOMBS_ON_LOSE_EN
                (state_q == S_LOSE && sweep_on_q) ? sweep_q :
`endif
                6'd0;
    game_won  = state_q == S_WIN;
    game_lost = state_q == S_LOSE && !sweep_on;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      revealed_q  <= '0;
      flagged_q   <= '0;
      count_q     <= '0;
      flags_q     <= FLAGS0;
      scan_q      <= '0;
      changed_q   <= 1'b0;
      gen_start_q <= 1'b0;
`ifdef REVEAL_BOMBS_ON_LOSE_EN
      sweep_q     <= '0;
      sweep_on_q  <= 1'b0;
`endif
    end else if (restart) begin
      row_q       <= '0;
      col_q       <= '0;
      revealed_q  <= '0;
      flagged_q   <= '0;
      count_q     <= '0;
      flags_q     <= FLAGS0;
      scan_q      <= '0;
      changed_q   <= 1'b0;
      gen_start_q <= 1'b1;
`ifdef REVEAL_BOMBS_ON_LOSE_EN
      sweep_q     <= '0;
      sweep_on_q  <= 1'b0;
`endif
    end else begin
      gen_start_q <= 1'b0;
      case (state_q)
        S_PLAY:
          if (!btn_reveal) begin
            if (btn_flag) begin
              if (!revealed_q[cur] && flagged_q[cur]) begin
                flagged_q[cur] <= 1'b0;
                flags_q        <= flags_q + 8'd1;
              end else if (!revealed_q[cur] && flags_q != 8'd0) begin
                flagged_q[cur] <= 1'b1;
                flags_q        <= flags_q - 8'd1;
              end
            end
            else if (btn_up)    row_q <= row_q - 3'd1;
            else if (btn_down)  row_q <= row_q + 3'd1;
            else if (btn_left)  col_q <= col_q - 3'd1;
            else if (btn_right) col_q <= col_q + 3'd1;
          end
        S_CHECK: begin
          revealed_q[cur] <= 1'b1;
          if (!cell_data[5]) count_q <= count_inc;
          scan_q    <= '0;
          changed_q <= 1'b0;
`ifdef REVEAL_BOMBS_ON_LOSE_EN
          sweep_q    <= '0;
          sweep_on_q <= cell_data[5];
`endif
        end
        S_FLOOD: begin
          revealed_q <= revealed_q | new_bits;
          count_q    <= sat_add(count_q, n_new);
          changed_q  <= (scan_q != 6'd63) && (changed_q || n_new != 4'd0);
          scan_q     <= scan_q + 6'd1;
        end
`ifdef REVEAL_BOMBS_ON_LOSE_EN
        S_LOSE:
          if (sweep_on_q) begin
            if (cell_data[5]) revealed_q[sweep_q] <= 1'b1;
            sweep_q <= sweep_q + 6'd1;
            if (&sweep_q) sweep_on_q <= 1'b0;
          end
`endif
        default: ;
      endcase
    end

  assign gen_start      = gen_start_q;
  assign cursor_row     = row_q;
  assign cursor_col     = col_q;
  assign revealed       = revealed_q;
  assign flagged        = flagged_q;
  assign revealed_count = count_q;
  assign flags_left     = flags_q;
  assign state          = state_q;
endmodule
